// File: rtl/mesh_edge_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : mesh_edge_port_bank
// Purpose  : Bank of mesh boundary ports. Each port has a credit-gated
//            injection path and a buffered receive path that returns credits.
// Revision : 1.0 - initial release
// ============================================================================
module mesh_edge_port_bank #(
    parameter int NUM_PORTS     = 2,
    parameter int CHANNEL_WIDTH = 32,
    parameter int TX_CREDITS    = 4,
    parameter int RX_DEPTH      = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS*(CHANNEL_WIDTH-1)-1:0] tx_data,
    input  logic [NUM_PORTS-1:0]                   tx_valid,
    output logic [NUM_PORTS-1:0]                   tx_ready,
    output logic [NUM_PORTS*CHANNEL_WIDTH-1:0]     channel_dout,
    input  logic [NUM_PORTS-1:0]                   credit_in_din,
    input  logic [NUM_PORTS*CHANNEL_WIDTH-1:0]     channel_din,
    output logic [NUM_PORTS-1:0]                   credit_out_dout,
    output logic [NUM_PORTS*(CHANNEL_WIDTH-1)-1:0] rx_data,
    output logic [NUM_PORTS-1:0]                   rx_valid,
    input  logic [NUM_PORTS-1:0]                   rx_ready,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]         tx_count,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]         rx_count,
    output logic [NUM_PORTS*2-1:0]                 err_flags
);

    localparam int c_PW     = CHANNEL_WIDTH - 1;
    localparam int c_CRED_W = $clog2(TX_CREDITS + 1);
    localparam int c_AW     = $clog2(RX_DEPTH);
    localparam int c_PTR_W  = c_AW + 1;

    localparam logic [c_CRED_W-1:0]  c_CRED_MAX = c_CRED_W'(TX_CREDITS);
    localparam logic [c_CRED_W-1:0]  c_CRED_ONE = c_CRED_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_FULL = {1'b1, {c_AW{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [c_CRED_W-1:0]      credit_q, credit_d;
            logic [CHANNEL_WIDTH-1:0] dout_q, dout_d;
            logic [CNT_WIDTH-1:0]     txc_q, txc_d, rxc_q, rxc_d;
            logic                     cerr_q, cerr_d, rerr_q, rerr_d;
            logic                     cout_q, cout_d;
            logic [c_PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
            logic [c_PW-1:0]          mem_q [RX_DEPTH];

            logic                     w_ready, w_xfer, w_cin, w_arrive;
            logic                     w_empty, w_full, w_pop, w_push;
            logic [c_PW-1:0]          w_tx_payload, w_rx_payload;

            assign w_tx_payload = tx_data[p*c_PW +: c_PW];
            assign w_rx_payload = channel_din[p*CHANNEL_WIDTH+1 +: c_PW];
            assign w_arrive     = channel_din[p*CHANNEL_WIDTH];
            assign w_cin        = credit_in_din[p];

            assign w_ready = (credit_q != '0);
            assign w_xfer  = tx_valid[p] & w_ready;
            assign w_empty = (wr_q == rd_q);
            assign w_full  = ((wr_q ^ rd_q) == c_PTR_FULL);
            assign w_pop   = ~w_empty & rx_ready[p];
            // A full FIFO can still take a flit when the head leaves this cycle.
            assign w_push  = w_arrive & (~w_full | w_pop);

            always_comb begin
                credit_d = credit_q;
                dout_d   = '0;
                txc_d    = txc_q;
                rxc_d    = rxc_q;
                cerr_d   = cerr_q;
                rerr_d   = rerr_q;
                cout_d   = w_pop;
                wr_d     = wr_q;
                rd_d     = rd_q;

                if (w_xfer) begin
                    dout_d = {w_tx_payload, 1'b1};
                    txc_d  = txc_q + c_CNT_ONE;
                end

                if (w_xfer && !w_cin) begin
                    credit_d = credit_q - c_CRED_ONE;
                end else if (w_cin && !w_xfer) begin
                    if (credit_q == c_CRED_MAX) begin
                        cerr_d = 1'b1;
                    end else begin
                        credit_d = credit_q + c_CRED_ONE;
                    end
                end

                if (w_pop) begin
                    rd_d = rd_q + c_PTR_ONE;
                end
                if (w_push) begin
                    wr_d  = wr_q + c_PTR_ONE;
                    rxc_d = rxc_q + c_CNT_ONE;
                end else if (w_arrive) begin
                    rerr_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    credit_q <= c_CRED_MAX;
                    dout_q   <= '0;
                    txc_q    <= '0;
                    rxc_q    <= '0;
                    cerr_q   <= 1'b0;
                    rerr_q   <= 1'b0;
                    cout_q   <= 1'b0;
                    wr_q     <= '0;
                    rd_q     <= '0;
                end else begin
                    credit_q <= credit_d;
                    dout_q   <= dout_d;
                    txc_q    <= txc_d;
                    rxc_q    <= rxc_d;
                    cerr_q   <= cerr_d;
                    rerr_q   <= rerr_d;
                    cout_q   <= cout_d;
                    wr_q     <= wr_d;
                    rd_q     <= rd_d;
                end
            end

            // Storage needs no reset; the pointers define which entries are live.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    mem_q[wr_q[c_AW-1:0]] <= w_rx_payload;
                end
            end

            assign tx_ready[p]                             = w_ready;
            assign channel_dout[p*CHANNEL_WIDTH +: CHANNEL_WIDTH] = dout_q;
            assign credit_out_dout[p]                      = cout_q;
            assign rx_valid[p]                             = ~w_empty;
            assign rx_data[p*c_PW +: c_PW]                 = mem_q[rd_q[c_AW-1:0]];
            assign tx_count[p*CNT_WIDTH +: CNT_WIDTH]      = txc_q;
            assign rx_count[p*CNT_WIDTH +: CNT_WIDTH]      = rxc_q;
            assign err_flags[p*2 +: 2]                     = {cerr_q, rerr_q};
        end
    endgenerate

endmodule
`default_nettype wire
